// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point datapath blocks (divider, multiplier).
// FIXED_DIVIDER_ROUND_NEAREST_EN adds one extra quotient iteration for rounding.
package fixed_point_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned FRAC_DEF  = 7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam logic [WIDTH_DEF-1:0] MAX_POS = {1'b0, {(WIDTH_DEF-1){1'b1}}};
  localparam logic [WIDTH_DEF-1:0] MIN_NEG = {1'b1, {(WIDTH_DEF-1){1'b0}}};

  // Quotient bits produced per division; the rounding build needs one guard bit.
  function automatic int unsigned div_iters(input int unsigned width, input int unsigned frac);
`ifdef FIXED_DIVIDER_ROUND_NEAREST_EN
    return width + frac + 1;
`else
    return width + frac;
`endif
  endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/finish handshake bundle shared by the fixed-point divider and multiplier.
interface fixed_point_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             overflow_flag;
  logic             div_by_zero;
  logic             finish;

  modport master (
    output dividend, divisor, start,
    input  result, overflow_flag, div_by_zero, finish
  );

  modport slave (
    input  dividend, divisor, start,
    output result, overflow_flag, div_by_zero, finish
  );
endinterface

// File: rtl/fixed_point_divider_adder.sv
// Parameterised adder/subtractor shared across the fixed-point datapath.
module adder #(
  parameter int unsigned WIDTH       = 16,
  parameter bit          is_subtract = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  localparam logic [WIDTH-1:0] CIN = {{(WIDTH-1){1'b0}}, is_subtract};

  logic [WIDTH-1:0] b_eff;

  assign b_eff = is_subtract ? ~b : b;
  assign sum   = a + b_eff + CIN;
endmodule

// File: rtl/fixed_point_divider.sv
// Sequential signed Q-format divider: restoring radix-2 on magnitudes, then sign-fix/saturate.
// Define FIXED_DIVIDER_ROUND_NEAREST_EN for round-half-away-from-zero instead of truncation.
module fixed_point_divider
  import fixed_point_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned FRAC_BITS = FRAC_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fixed_point_divider_if.slave bus
);
  localparam int unsigned ITERS = div_iters(WIDTH, FRAC_BITS);
  localparam int unsigned CNTW  = $clog2(ITERS + 1);
  localparam int unsigned MAGW  = ITERS + 1;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [MAGW-1:0]  LIM_POS = MAGW'(SAT_POS);
  localparam logic [MAGW-1:0]  LIM_NEG = MAGW'(SAT_NEG);

  div_state_e state_q, state_d;

  logic             start_seen;
  logic [ITERS-1:0] num_q;
  logic [ITERS-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] b_mag_q;
  logic [CNTW-1:0]  cnt_q;
  logic             sign_q;
  logic             dsign_q;

  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             dz_q;
  logic             finish_q;

  logic             launch;
  logic             last_iter;
  logic [WIDTH-1:0] neg_dividend, neg_divisor, abs_dividend, abs_divisor;
  logic [WIDTH:0]   rem_shift, trial;
  logic             no_borrow;
  logic [MAGW-1:0]  mag;
  logic [WIDTH-1:0] neg_mag;
  logic             mag_ovf;
  logic [WIDTH-1:0] fix_result;

  assign launch    = bus.start && !start_seen && (state_q == IDLE || state_q == DONE);
  assign last_iter = (cnt_q == CNTW'(ITERS - 1));

  adder #(.WIDTH(WIDTH), .is_subtract(1'b1)) u_neg_dividend (
    .a('0), .b(bus.dividend), .sum(neg_dividend)
  );
  adder #(.WIDTH(WIDTH), .is_subtract(1'b1)) u_neg_divisor (
    .a('0), .b(bus.divisor), .sum(neg_divisor)
  );

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct read as unsigned.
  assign abs_dividend = bus.dividend[WIDTH-1] ? neg_dividend : bus.dividend;
  assign abs_divisor  = bus.divisor[WIDTH-1]  ? neg_divisor  : bus.divisor;

  assign rem_shift = {rem_q, num_q[ITERS-1]};

  adder #(.WIDTH(WIDTH + 1), .is_subtract(1'b1)) u_trial (
    .a(rem_shift), .b({1'b0, b_mag_q}), .sum(trial)
  );

  // Both operands are below 2^WIDTH, so the extra top bit of the difference is the borrow.
  assign no_borrow = ~trial[WIDTH];

`ifdef FIXED_DIVIDER_ROUND_NEAREST_EN
  adder #(.WIDTH(MAGW), .is_subtract(1'b0)) u_round (
    .a({2'b00, quo_q[ITERS-1:1]}),
    .b({{(MAGW-1){1'b0}}, quo_q[0]}),
    .sum(mag)
  );
`else
  assign mag = {1'b0, quo_q};
`endif

  adder #(.WIDTH(WIDTH), .is_subtract(1'b1)) u_negate (
    .a('0), .b(mag[WIDTH-1:0]), .sum(neg_mag)
  );

  assign mag_ovf = sign_q ? (mag > LIM_NEG) : (mag > LIM_POS);

  always_comb begin
    fix_result = mag[WIDTH-1:0];
    if (b_mag_q == '0)
      fix_result = dsign_q ? SAT_NEG : SAT_POS;
    else if (mag_ovf)
      fix_result = sign_q ? SAT_NEG : SAT_POS;
    else if (sign_q)
      fix_result = neg_mag;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (launch) state_d = (bus.divisor == '0) ? FIX : CALC;
      CALC:       if (last_iter) state_d = FIX;
      FIX:        state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_seen <= 1'b0;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      b_mag_q    <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      dsign_q    <= 1'b0;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      start_seen <= bus.start;
      if (launch) begin
        num_q    <= {abs_dividend, {(ITERS-WIDTH){1'b0}}};
        b_mag_q  <= abs_divisor;
        sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
        dsign_q  <= bus.dividend[WIDTH-1];
        rem_q    <= '0;
        quo_q    <= '0;
        cnt_q    <= '0;
        finish_q <= 1'b0;
        ovf_q    <= 1'b0;
        dz_q     <= 1'b0;
      end else begin
        unique case (state_q)
          CALC: begin
            num_q <= num_q << 1;
            rem_q <= no_borrow ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quo_q <= {quo_q[ITERS-2:0], no_borrow};
            cnt_q <= cnt_q + CNTW'(1);
          end
          FIX: begin
            result_q <= fix_result;
            dz_q     <= (b_mag_q == '0);
            ovf_q    <= (b_mag_q != '0) && mag_ovf;
            finish_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.result        = result_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.div_by_zero   = dz_q;
  assign bus.finish        = finish_q;
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
Sequential signed fixed-point divider: result = dividend / divisor, all operands in two's-complement Q(WIDTH-FRAC_BITS).FRAC_BITS.
Companion to the fixed-point multiplier in the ODE accelerator datapath, used for step-size and coefficient division.
Uses the same start/finish handshake as the multiplier, so the controller drives both blocks identically.
Radix-2 restoring division on magnitudes, one quotient bit per cycle, followed by a sign-fix/saturate cycle.

Parameters:
WIDTH, 16, operand and result width in bits
FRAC_BITS, 7, number of fractional bits in operands and result

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
dividend  input  WIDTH  signed fixed-point numerator; sampled at launch
divisor  input  WIDTH  signed fixed-point denominator; sampled at launch
start  input  1  level; a 0->1 transition (as seen at a clock edge) launches one division
result  output  WIDTH  signed fixed-point quotient; valid while finish=1
overflow_flag  output  1  quotient not representable, result saturated; valid while finish=1
div_by_zero  output  1  divisor was 0, result saturated; valid while finish=1
finish  output  1  high from completion until the next launch or reset

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; result, overflow_flag, div_by_zero, finish all 0; operand buffers, remainder, quotient and counter all 0; start_seen = 0.
- Launch: a clock edge with start=1 and start_seen=0 launches. Aborts nothing.
  - Captures |dividend|, |divisor| and sign = dividend[MSB] xor divisor[MSB].
  - Captures dividend[MSB] as dsign (used for the divide-by-zero case).
  - Clears finish, overflow_flag and div_by_zero; sets start_seen=1.
  - start_seen clears on any edge where start=0.
- Busy: start rising while not IDLE/DONE is ignored; the operation completes normally.
- States:
  - IDLE -> CALC on launch (divisor != 0).
  - IDLE/DONE -> FIX on launch with divisor == 0.
  - CALC: N = WIDTH+FRAC_BITS iterations. Numerator is |dividend| << FRAC_BITS, shifted MSB-first into a WIDTH+1-bit partial remainder. Trial-subtract |divisor|; quotient bit = 1 if no borrow (remainder updated), else 0 (remainder restored). Counter counts 0..N-1, then -> FIX.
  - FIX (1 cycle):
    - Divide by zero: result = dsign ? 0x8000 : 0x7FFF (generalised to WIDTH); div_by_zero=1; overflow_flag=0.
    - Otherwise, for quotient magnitude q: if sign=0 and q > 2^(WIDTH-1)-1, or sign=1 and q > 2^(WIDTH-1): saturate to max positive / min negative and set overflow_flag=1. Else result = sign ? -q : q.
    - Sets finish=1 -> DONE.
  - DONE: outputs held stable until the next launch or reset.
- Latency, counted from the launch edge to the edge that raises finish: N+1 = 24 cycles for default parameters; 1 cycle for divide by zero.
- Magnitude of min negative (0x8000) = 2^(WIDTH-1); it is held unsigned in WIDTH bits, no overflow.
- A zero dividend gives result 0 with no flags set.
- Reset mid-operation returns to IDLE immediately; no finish pulse is produced.

Optional Feature:
FIXED_DIVIDER_ROUND_NEAREST_EN:
- Defined: CALC runs N+1 iterations; the extra LSB is a rounding bit. FIX adds it to the magnitude (round half away from zero) before the overflow check and negation. Latency 25 cycles.
- Undefined: truncation toward zero, latency 24 cycles.

Decomposition:
- Shared package (fixed_point_pkg):
  - WIDTH and FRAC_BITS defaults.
  - State encoding IDLE/CALC/FIX/DONE.
  - MAX_POS / MIN_NEG saturation constants.
  - Iteration-count constant.
- Reuse the existing adder module (parameterised, is_subtract=1) for the trial subtract.
- Reuse it for the negation/increment.
- No new sub-module needed.

Test Plan:
1. 0x0180 / 0x0100 (3.0/2.0) -> result 0x00C0, flags 0, finish rises 24 cycles after launch.
2. 0xFE80 / 0x0100 (-3.0/2.0) -> 0xFF40. 0xFE80 / 0xFF00 (-3.0/-2.0) -> 0x00C0.
3. 0x0080 / 0x0180 (1/3) -> 0x002A when truncating; 0x002B with ROUND_NEAREST_EN, finish at cycle 25.
4. Overflow:
   - 0x4000 / 0x0001 -> 0x7FFF, overflow_flag=1.
   - 0x8000 / 0xFF80 (-256/-1) -> 0x7FFF, overflow_flag=1.
   - 0x8000 / 0x0080 -> 0x8000, no overflow.
5. 0x0100 / 0x0000 -> 0x7FFF, div_by_zero=1, finish 1 cycle after launch. 0xFF00 / 0x0000 -> 0x8000.
6. Handshake and reset:
   - start held high across completion -> no relaunch.
   - start re-pulsed mid-CALC -> ignored, result unchanged.
   - rst=0 at iteration 10 -> all outputs 0; a fresh launch after release completes correctly.
